ws2812_rx_decoder: RTL and testbench

Serial decoder for the WS2812B single-wire LED protocol, clocked at 100 MHz on the BASYS 3. It measures high-pulse widths on the incoming data line and slices each pulse into a 0 or 1. It assembles MSB-first 24-bit GRB words, detects the ≥50 µs low frame-reset, and forwards the line onward after the first word, as a real LED does. It is the receive end of the LED transmit path: it serves as a loopback checker for the bit generator and as an emulated first pixel.

---
 rtl/ws2812_rx_decoder.sv | 151 +++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_decoder.sv
// WS2812B receive decoder: slices high-pulse widths into bits, assembles MSB-first GRB words,
// detects the long low frame reset and forwards the line onward once the first word is consumed.
module ws2812_rx_decoder #(
  parameter int T_THRESH  = 60,
  parameter int MIN_HIGH  = 10,
  parameter int MAX_HIGH  = 127,
  parameter int RESET_CNT = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic [7:0]  pixel_idx,
  output logic        frame_end,
  output logic [7:0]  pixel_count,
  output logic        err,
  output logic        dout
);

  localparam logic [6:0]  TH_C     = 7'(T_THRESH);
  localparam logic [6:0]  MIN_C    = 7'(MIN_HIGH);
  localparam logic [6:0]  MAX_C    = 7'(MAX_HIGH);
  localparam logic [12:0] RST_C    = 13'(RESET_CNT);
  localparam logic [12:0] RST_M1_C = 13'(RESET_CNT - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_RST} state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic        rise, fall, bitVal, endLow;
  logic [6:0]  hCnt;
  logic [12:0] lCnt;
  logic [4:0]  bitCnt;
  logic [23:0] shReg;
  logic [7:0]  wordCnt;
  logic        fwd;

  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;
  assign bitVal = (hCnt >= TH_C);
  // Fires on the cycle whose clock edge brings lCnt to RESET_CNT, so frame_end lands one edge later.
  assign endLow = ~s2 && (lCnt == RST_M1_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      hCnt <= '0;
      lCnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (rise)
        hCnt <= 7'd1;
      else if (s2 && hCnt != MAX_C)
        hCnt <= hCnt + 7'd1;
      if (rise)
        lCnt <= '0;
      else if (!s2 && lCnt != RST_C)
        lCnt <= lCnt + 13'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_out    <= '0;
      data_valid  <= 1'b0;
      pixel_idx   <= '0;
      frame_end   <= 1'b0;
      pixel_count <= '0;
      err         <= 1'b0;
      dout        <= 1'b0;
      fwd         <= 1'b0;
      bitCnt      <= '0;
      shReg       <= '0;
      wordCnt     <= '0;
    end else begin
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      err        <= 1'b0;
      dout       <= fwd ? s2 : 1'b0;
      case (state)
        IDLE: begin
          if (rise)
            state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            if (hCnt < MIN_C) begin
              err   <= 1'b1;
              state <= LOW;
            end else if (hCnt < MAX_C) begin
              shReg <= {shReg[22:0], bitVal};
              if (bitCnt == 5'd23) begin
                data_out   <= {shReg[22:0], bitVal};
                data_valid <= 1'b1;
                pixel_idx  <= wordCnt;
                if (wordCnt != 8'hFF)
                  wordCnt <= wordCnt + 8'd1;
                bitCnt <= '0;
                fwd    <= 1'b1;
              end else begin
                bitCnt <= bitCnt + 5'd1;
              end
              state <= LOW;
            end else begin
              // Pulse ended exactly as the counter saturated: still too long to be a bit.
              err    <= 1'b1;
              bitCnt <= '0;
              state  <= WAIT_RST;
            end
          end else if (s2 && hCnt == MAX_C) begin
            err    <= 1'b1;
            bitCnt <= '0;
            state  <= WAIT_RST;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (endLow) begin
            frame_end   <= 1'b1;
            pixel_count <= wordCnt;
            wordCnt     <= '0;
            fwd         <= 1'b0;
            if (bitCnt != 5'd0)
              err <= 1'b1;
            bitCnt <= '0;
            state  <= IDLE;
          end
        end
        WAIT_RST: begin
          if (endLow) begin
            frame_end   <= 1'b1;
            pixel_count <= wordCnt;
            wordCnt     <= '0;
            fwd         <= 1'b0;
            bitCnt      <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: stimulus pushes expected events, a negedge monitor pops
// and compares them whenever the decoder pulses data_valid, frame_end or err.
`timescale 1ns/1ps
module tb_ws2812_rx_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] data_out;
  logic        data_valid;
  logic [7:0]  pixel_idx;
  logic        frame_end;
  logic [7:0]  pixel_count;
  logic        err;
  logic        dout;

  always #5 clk = ~clk;

  ws2812_rx_decoder dut (
    .clk(clk), .reset(reset), .din(din),
    .data_out(data_out), .data_valid(data_valid), .pixel_idx(pixel_idx),
    .frame_end(frame_end), .pixel_count(pixel_count), .err(err), .dout(dout)
  );

  typedef struct {logic [23:0] data; logic [7:0] idx;} dv_t;
  typedef struct {logic [7:0] cnt; logic errToo;} fe_t;

  dv_t  dvQ[$];
  fe_t  feQ[$];
  logic errQ[$];   // each entry: whether frame_end must coincide

  int checks = 0;
  int errors = 0;

  logic [2:0] dinHist = 3'b000;
  logic       chkZero = 1'b0;
  logic       chkFwd  = 1'b0;
  int         zeroBad = 0;
  int         fwdBad  = 0;
  int         fwdOnes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) dinHist <= {dinHist[1:0], din};

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (data_valid) begin
        if (dvQ.size() == 0) check("unexpected data_valid", 32'(data_valid), 32'd0);
        else begin
          dv_t e;
          e = dvQ.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("pixel_idx", 32'(pixel_idx), 32'(e.idx));
          $display("data_valid: data_out=%06h pixel_idx=%0d", data_out, pixel_idx);
        end
      end
      if (frame_end) begin
        if (feQ.size() == 0) check("unexpected frame_end", 32'(frame_end), 32'd0);
        else begin
          fe_t f;
          f = feQ.pop_front();
          check("pixel_count", 32'(pixel_count), 32'(f.cnt));
          check("err_with_frame_end", 32'(err), 32'(f.errToo));
          $display("frame_end: pixel_count=%0d err=%0d", pixel_count, err);
        end
      end
      if (err) begin
        if (errQ.size() == 0) check("unexpected err", 32'(err), 32'd0);
        else begin
          logic withFe;
          withFe = errQ.pop_front();
          check("frame_end_with_err", 32'(frame_end), 32'(withFe));
          $display("err: frame_end=%0d", frame_end);
        end
      end
      if (chkZero && dout !== 1'b0) zeroBad++;
      if (chkFwd) begin
        if (dout !== dinHist[2]) fwdBad++;
        if (dout === 1'b1) fwdOnes++;
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    @(negedge clk) din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    if (b) pulse(70, 50);
    else   pulse(50, 70);
  endtask

  task automatic sendBits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) sendBit(w[i]);
  endtask

  task automatic gap();
    repeat (5010) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " data_out"},    32'(data_out),    32'd0);
    check({tag, " data_valid"},  32'(data_valid),  32'd0);
    check({tag, " pixel_idx"},   32'(pixel_idx),   32'd0);
    check({tag, " frame_end"},   32'(frame_end),   32'd0);
    check({tag, " pixel_count"}, 32'(pixel_count), 32'd0);
    check({tag, " err"},         32'(err),         32'd0);
    check({tag, " dout"},        32'(dout),        32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkAllZero("reset");

    // Single word
    dvQ.push_back('{24'hA5C3F0, 8'd0});
    feQ.push_back('{8'd1, 1'b0});
    sendBits(24'hA5C3F0, 24);
    gap();

    // Two-word frame with forwarding
    dvQ.push_back('{24'h123456, 8'd0});
    dvQ.push_back('{24'hFEDCBA, 8'd1});
    feQ.push_back('{8'd2, 1'b0});
    chkZero = 1'b1;
    sendBits(24'h123456, 24);
    chkZero = 1'b0;
    chkFwd = 1'b1;
    sendBits(24'hFEDCBA, 24);
    repeat (5) @(negedge clk);
    chkFwd = 1'b0;
    gap();
    check("dout_nonzero_first_word_cycles", 32'(zeroBad), 32'd0);
    check("dout_fwd_mismatch_cycles", 32'(fwdBad), 32'd0);
    check("dout_fwd_high_cycles", 32'(fwdOnes), 32'(17 * 70 + 7 * 50));

    // Reset mid-word
    sendBits(24'hABC000, 12);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checkAllZero("midreset");
    dvQ.push_back('{24'h0F0F0F, 8'd0});
    feQ.push_back('{8'd1, 1'b0});
    sendBits(24'h0F0F0F, 24);
    gap();

    // Glitch between bits 7 and 8
    errQ.push_back(1'b0);
    dvQ.push_back('{24'h00FF00, 8'd0});
    feQ.push_back('{8'd1, 1'b0});
    sendBits(24'h000000, 7);
    pulse(50, 30);
    pulse(5, 40);
    for (int i = 15; i >= 0; i--) sendBit(i >= 8);
    gap();

    // Overlong pulse after 4 bits, then a full word that must be ignored
    errQ.push_back(1'b0);
    feQ.push_back('{8'd0, 1'b0});
    sendBits(24'h500000, 4);
    pulse(130, 50);
    sendBits(24'hABCDEF, 24);
    gap();

    // Partial word at frame end
    errQ.push_back(1'b1);
    feQ.push_back('{8'd0, 1'b1});
    sendBits(24'h3FF000, 10);
    gap();

    repeat (20) @(negedge clk);
    check("missing data_valid events", 32'(dvQ.size()), 32'd0);
    check("missing frame_end events", 32'(feQ.size()), 32'd0);
    check("missing err events", 32'(errQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
